// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the SAP CPU control sequencer.
//   - opcode constants (IR upper nibble)
//   - T-state encodings T1..T6 as carried on the 3-bit tstate bus
package cpu_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JZ  = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5,
      T6 = 3'd6
   } tstate_e;

endpackage

// File: rtl/cpu_ring_counter.sv
// cpu_ring_counter: T-state sequencer, T1 -> T2 -> ... -> T6 -> T1.
// Ports:
//   clk    in   system clock, posedge active
//   rst    in   asynchronous active-low reset, forces T1
//   clear  in   return to T1 at the next edge (short-cycled instruction)
//   hold   in   keep the current T-state (halt freeze), wins over clear
//   tstate out  current T-state, 1..6
module cpu_ring_counter
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       hold,
   output logic [2:0] tstate
);

   tstate_e tstate_q, tstate_d;

   always_comb begin
      tstate_d = tstate_q;
      if (hold) begin
         tstate_d = tstate_q;
      end else if (clear) begin
         tstate_d = T1;
      end else begin
         case (tstate_q)
            T1:      tstate_d = T2;
            T2:      tstate_d = T3;
            T3:      tstate_d = T4;
            T4:      tstate_d = T5;
            T5:      tstate_d = T6;
            default: tstate_d = T1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tstate_q <= T1;
      else      tstate_q <= tstate_d;
   end

   assign tstate = tstate_q;

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: control sequencer for the 4-bit SAP CPU.
// Fetch runs in T1..T3, the IR opcode is decoded into one-hot strobes in T4..T6.
// Strobes are combinational decodes of the registered T-state, ir_opcode and the
// halted flag, so while rst is low they show the T1 fetch strobes.
// Parameters:
//   OP_W         opcode width (IR upper nibble)
//   SHORT_CYCLE  1: jump back to T1 after the last active execute step
//                0: every instruction runs all six T-states
// Build option: define CPU_CTRL_COND_JUMP_EN to enable JZ (0x5) / JC (0x6);
// otherwise both decode as NOP and flag_z / flag_c are ignored.
// Ports:
//   clk, rst (async active-low), ir_opcode, flag_z, flag_c    inputs
//   pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
//   a_load, a_oe, b_load, alu_oe, alu_sub, out_load           strobes
//   halted (CPU stopped), tstate (1..6)                        status
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int OP_W        = 4,
   parameter bit SHORT_CYCLE = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] ir_opcode,
   input  logic            flag_z,
   input  logic            flag_c,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            pc_oe,
   output logic            mar_load,
   output logic            ram_oe,
   output logic            ram_we,
   output logic            ir_load,
   output logic            ir_oe,
   output logic            a_load,
   output logic            a_oe,
   output logic            b_load,
   output logic            alu_oe,
   output logic            alu_sub,
   output logic            out_load,
   output logic            halted,
   output logic [2:0]      tstate
);

   logic halted_q, halted_d;
   logic last_step;   // final active execute step of a short instruction
   logic halt_now;    // HLT decoded in T4
   logic clear;
   logic hold;
   logic jz_take, jc_take;

`ifdef CPU_CTRL_COND_JUMP_EN
   assign jz_take = flag_z;
   assign jc_take = flag_c;
`else
   logic unused_flags;
   assign unused_flags = flag_z ^ flag_c;
   assign jz_take      = 1'b0;
   assign jc_take      = 1'b0;
`endif

   always_comb begin
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      pc_oe     = 1'b0;
      mar_load  = 1'b0;
      ram_oe    = 1'b0;
      ram_we    = 1'b0;
      ir_load   = 1'b0;
      ir_oe     = 1'b0;
      a_load    = 1'b0;
      a_oe      = 1'b0;
      b_load    = 1'b0;
      alu_oe    = 1'b0;
      alu_sub   = 1'b0;
      out_load  = 1'b0;
      last_step = 1'b0;
      halt_now  = 1'b0;
      if (!halted_q) begin
         case (tstate)
            T1: begin pc_oe = 1'b1; mar_load = 1'b1; end
            T2: pc_inc = 1'b1;
            T3: begin ram_oe = 1'b1; ir_load = 1'b1; end
            T4: begin
               case (ir_opcode)
                  OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_STA): begin
                     ir_oe    = 1'b1;
                     mar_load = 1'b1;
                  end
                  OP_W'(OP_JMP): begin
                     ir_oe     = 1'b1;
                     pc_load   = 1'b1;
                     last_step = 1'b1;
                  end
                  // Untaken conditional jumps fall through as a NOP.
                  OP_W'(OP_JZ): begin
                     ir_oe     = jz_take;
                     pc_load   = jz_take;
                     last_step = 1'b1;
                  end
                  OP_W'(OP_JC): begin
                     ir_oe     = jc_take;
                     pc_load   = jc_take;
                     last_step = 1'b1;
                  end
                  OP_W'(OP_OUT): begin
                     a_oe      = 1'b1;
                     out_load  = 1'b1;
                     last_step = 1'b1;
                  end
                  OP_W'(OP_HLT): halt_now = 1'b1;
                  default:       last_step = 1'b1;
               endcase
            end
            T5: begin
               case (ir_opcode)
                  OP_W'(OP_LDA): begin
                     ram_oe    = 1'b1;
                     a_load    = 1'b1;
                     last_step = 1'b1;
                  end
                  OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                     ram_oe  = 1'b1;
                     b_load  = 1'b1;
                     alu_sub = (ir_opcode == OP_W'(OP_SUB));
                  end
                  OP_W'(OP_STA): begin
                     a_oe      = 1'b1;
                     ram_we    = 1'b1;
                     last_step = 1'b1;
                  end
                  default: ;
               endcase
            end
            T6: begin
               if (ir_opcode == OP_W'(OP_ADD) || ir_opcode == OP_W'(OP_SUB)) begin
                  alu_oe  = 1'b1;
                  a_load  = 1'b1;
                  alu_sub = (ir_opcode == OP_W'(OP_SUB));
               end
            end
            default: ;
         endcase
      end
   end

   // HLT freezes the counter on the same edge that sets halted, so tstate
   // stays at T4 for as long as the CPU is stopped.
   assign halted_d = halted_q | halt_now;
   assign hold     = halted_q | halt_now;
   assign clear    = SHORT_CYCLE & last_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) halted_q <= 1'b0;
      else      halted_q <= halted_d;
   end

   assign halted = halted_q;

   cpu_ring_counter u_ring (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .hold   (hold),
      .tstate (tstate)
   );

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control sequencer for the 4-bit SAP CPU; sits directly upstream of the program counter and drives its count-enable and load-enable inputs.
- Steps through fetch (T1–T3) and execute (T4–T6) states.
- Decodes the IR opcode nibble into one-hot bus/load/enable strobes for the PC, MAR, RAM, IR, A, B, ALU and output register.

Parameters:
- OP_W, 4, opcode width taken from the IR upper nibble.
- SHORT_CYCLE, 1: 1 = return to T1 right after the last active execute step; 0 = always run all six T-states.

Ports:
- clk  input  1  system clock, posedge active
- rst  input  1  asynchronous, active-low reset
- ir_opcode  input  OP_W  opcode field of the instruction register
- flag_z  input  1  accumulator-zero flag (used only with the optional feature)
- flag_c  input  1  ALU carry flag (used only with the optional feature)
- pc_inc  output  1  PC count enable (to PC c)
- pc_load  output  1  PC load from bus (to PC lp)
- pc_oe  output  1  PC drives bus
- mar_load  output  1  MAR load from bus
- ram_oe  output  1  RAM drives bus
- ram_we  output  1  RAM write from bus
- ir_load  output  1  IR load from bus
- ir_oe  output  1  IR operand nibble drives bus
- a_load, a_oe  output  1 each  accumulator load / drive bus
- b_load  output  1  B register load
- alu_oe, alu_sub  output  1 each  ALU drives bus / subtract select
- out_load  output  1  output register load
- halted  output  1  CPU stopped
- tstate  output  3  current T-state, 1..6

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset state: tstate=1, halted=0. Reset mid-instruction aborts it immediately with no partial strobes afterwards.
- Strobes are combinational decodes of the registered tstate, ir_opcode and halted. During reset they therefore show T1 values: pc_oe=1, mar_load=1, all others 0.
- tstate advances 1→2→…→6→1 on each posedge.
- Opcode decode applies in T4–T6 only. The IR loads at the T3→T4 edge, so T4 sees the new opcode.
- Fetch sequence:
  - T1: pc_oe, mar_load
  - T2: pc_inc
  - T3: ram_oe, ir_load
- Execute sequences, by opcode:
  - LDA 0x0: T4 ir_oe+mar_load; T5 ram_oe+a_load.
  - ADD 0x1: T4 ir_oe+mar_load; T5 ram_oe+b_load; T6 alu_oe+a_load.
  - SUB 0x2: as ADD, with alu_sub=1 in T5 and T6.
  - STA 0x3: T4 ir_oe+mar_load; T5 a_oe+ram_we.
  - JMP 0x4: T4 ir_oe+pc_load.
  - JZ 0x5 / JC 0x6: see Optional Feature.
  - OUT 0xE: T4 a_oe+out_load.
  - HLT 0xF: in T4, halted is set at the next edge; tstate then freezes and all strobes are 0 until reset.
  - Any other opcode: NOP, no strobes in T4–T6.
- Short cycling with SHORT_CYCLE=1, from the last active step:
  - LDA and STA: T5→T1.
  - JMP, OUT, NOP, untaken jump: T4→T1.
  - ADD and SUB: full six states.
- With SHORT_CYCLE=0, every instruction takes 6 cycles.
- Invariants:
  - At most one bus driver is active per cycle: pc_oe, ram_oe, ir_oe, a_oe, alu_oe are mutually exclusive.
  - pc_inc and pc_load are never both 1.

Optional Feature:
- Macro: CPU_CTRL_COND_JUMP_EN.
- Defined:
  - JZ: T4 ir_oe+pc_load if flag_z=1, sampled in T4.
  - JC: the same, using flag_c.
  - Not taken: no strobes, and the instruction behaves as a NOP for cycle length.
- Undefined: 0x5 and 0x6 decode as NOP; flag_z and flag_c are ignored.

Decomposition:
- Package cpu_pkg:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT
  - T-state encodings T1..T6
- Sub-module cpu_ring_counter:
  - ports: clk, rst, clear (return to T1), hold (halt freeze), tstate out
  - cpu_controller holds the decode logic only.

Test Plan:
- Reset asserted mid-T5 of ADD → tstate=1, halted=0, pc_oe=mar_load=1 immediately; normal fetch resumes after release.
- Opcode 0x1 (ADD) → strobe trace: T1 pc_oe/mar_load, T2 pc_inc, T3 ram_oe/ir_load, T4 ir_oe/mar_load, T5 ram_oe/b_load, T6 alu_oe/a_load; then back to T1.
- Opcode 0x0 with SHORT_CYCLE=1 → 5-cycle instruction, T5→T1. Same opcode with SHORT_CYCLE=0 → 6 cycles, T6 silent.
- Opcode 0x4 → pc_load=1 only in T4, pc_inc=0 in that cycle, next tstate=1.
- Opcode 0xF → halted=1 after the T4 edge; tstate and all strobes stay frozen for 20 cycles; reset clears halted.
- With CPU_CTRL_COND_JUMP_EN defined:
  - opcode 0x5, flag_z=1 → pc_load in T4
  - opcode 0x5, flag_z=0 → no strobes
  - undefined macro → no strobes in either case.
